cordic_sine_sched: RTL and testbench

//  Round-robin scheduler that shares one cordicsine core among NREQ requesters.
//  - Accepts angle requests and launches the core with a one-cycle update pulse.
//  - Holds the core angle stable for the whole computation, then captures the result.
//  - Returns the result tagged with the requester index.
//  - Sits between the sine consumers and the single core instance.

---
 rtl/cordic_sine_sched_if.sv | 27 ++
 rtl/cordic_sine_sched.sv | 138 +++++++++++++
 tb/tb_cordic_sine_sched.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sine_sched_if.sv
// Requester/consumer bundle for the shared CORDIC sine scheduler.
// master = requesters and response consumer; slave = the scheduler.
interface cordic_sine_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_angle;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_angle, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_angle, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/cordic_sine_sched.sv
// Round-robin front end sharing one cordicsine core among NREQ requesters;
// one transaction in flight, core angle held from accept until the response is taken.
module cordic_sine_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 63
) (
    input  logic                clk,
    input  logic                reset,
    cordic_sine_sched_if.slave  bus,
    output logic                busy,
    output logic                core_update,
    output logic [W-1:0]        core_angle,
    input  logic                core_ready,
    input  logic [W-1:0]        core_result
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] id;
    logic [TW-1:0] timer;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          rsp_valid;

    logic          gnt_found;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] next_ptr;
    logic          timed_out;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign next_ptr  = IW'((int'(id) + 1) % NREQ);
    assign timed_out = (timer == TW'(TIMEOUT));

    always_comb begin
        bus.req_ready = '0;
        if (!reset && state == IDLE && gnt_found)
            bus.req_ready = NREQ'(1) << gnt_idx;
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = id;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            id          <= '0;
            timer       <= '0;
            core_angle  <= '0;
            core_update <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        core_angle  <= bus.req_angle[gnt_idx*W +: W];
                        id          <= gnt_idx;
                        core_update <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    core_update <= 1'b0;
                    timer       <= '0;
                    state       <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!core_ready) begin
                        timer <= '0;
                        state <= WAIT_DONE;
                    end else if (timed_out) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (core_ready) begin
                        rsp_data  <= core_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end else if (timed_out) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESPOND: begin
                    // Fairness comes from restarting the search just past the winner.
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sine_sched.sv
// Directed bench for cordic_sine_sched with a stub core (ready drops after update,
// returns 17 cycles later with result = ~angle).
module tb_cordic_sine_sched;
    localparam int NREQ = 4;
    localparam int W    = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         busy, core_update, core_ready;
    logic [W-1:0] core_angle, core_result;

    always #5 clk = ~clk;

    cordic_sine_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    cordic_sine_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(63)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .core_update (core_update),
        .core_angle  (core_angle),
        .core_ready  (core_ready),
        .core_result (core_result)
    );

    logic stub_stuck;
    int   stub_cnt;

    always @(posedge clk) begin
        if (reset) begin
            core_ready  <= 1'b1;
            core_result <= '0;
            stub_cnt    <= 0;
        end else if (core_update && !stub_stuck) begin
            core_ready  <= 1'b0;
            core_result <= ~core_angle;
            stub_cnt    <= 17;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) core_ready <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    logic [3:0]  s_ready;
    logic        s_update, s_rvalid, s_rerr, s_busy;
    logic [1:0]  s_rid;
    logic [15:0] s_rdata, s_angle;
    int          grant_q[$], grant_cyc_q[$], upd_cyc_q[$], rsp_id_q[$], rsp_cyc_q[$];
    logic [15:0] rsp_data_q[$];
    logic        rsp_err_q[$];
    int          angle_bad = 0;
    logic [15:0] prev_angle = '0;
    logic        prev_ready_any = 1'b0;
    logic        prev_reset = 1'b1;

    // Sample on the falling edge, then release granted requesters after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_ready  = bus.req_ready;
        s_update = core_update;
        s_rvalid = bus.rsp_valid;
        s_rid    = bus.rsp_id;
        s_rdata  = bus.rsp_data;
        s_rerr   = bus.rsp_err;
        s_busy   = busy;
        s_angle  = core_angle;
        if (s_angle != prev_angle && !prev_ready_any && !prev_reset) angle_bad++;
        prev_angle     = s_angle;
        prev_ready_any = |s_ready;
        prev_reset     = reset;
        for (int k = 0; k < NREQ; k++)
            if (s_ready[k]) begin
                grant_q.push_back(k);
                grant_cyc_q.push_back(cyc);
            end
        if (s_update) upd_cyc_q.push_back(cyc);
        if (s_rvalid && bus.rsp_ready && !reset) begin
            rsp_id_q.push_back(int'(s_rid));
            rsp_data_q.push_back(s_rdata);
            rsp_err_q.push_back(s_rerr);
            rsp_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~s_ready;
    endtask

    task automatic wait_rsp(input string tag, input int maxc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!s_rvalid && n < maxc);
        chk({tag, "_rsp_seen"}, s_rvalid, 1);
    endtask

    task automatic run_until(input string tag, input int nrsp, input int maxc);
        int n = 0;
        while (rsp_id_q.size() < nrsp && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_count"}, rsp_id_q.size(), nrsp);
    endtask

    task automatic clear_logs();
        grant_q.delete(); grant_cyc_q.delete(); upd_cyc_q.delete();
        rsp_id_q.delete(); rsp_data_q.delete(); rsp_err_q.delete(); rsp_cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_cyc, bad, upd_n, mingap, gap, reraised, n;
        int          exp_id[5];
        logic [15:0] exp_dat[5];

        reset          = 1'b1;
        stub_stuck     = 1'b0;
        bus.req_valid  = '0;
        bus.req_angle  = '0;
        bus.rsp_ready  = 1'b0;
        tick();
        tick();
        chk("rst_busy", s_busy, 0);
        chk("rst_rsp_valid", s_rvalid, 0);
        chk("rst_update", s_update, 0);
        chk("rst_core_angle", s_angle, 0);
        chk("rst_rsp_data", s_rdata, 0);
        chk("rst_rsp_id", s_rid, 0);
        chk("rst_rsp_err", s_rerr, 0);
        chk("rst_req_ready", s_ready, 0);
        reset = 1'b0;
        tick();

        // Single request, then hold the response for 10 cycles.
        bus.req_angle[0*W +: W] = 16'h1000;
        bus.req_valid = 4'b0001;
        tick();
        chk("t1_req_ready", s_ready, 4'b0001);
        a_cyc = cyc;
        tick();
        chk("t1_update", s_update, 1);
        chk("t1_core_angle", s_angle, 16'h1000);
        chk("t1_busy", s_busy, 1);
        tick();
        chk("t1_update_once", s_update, 0);
        wait_rsp("t1", 40);
        chk("t1_latency", cyc - a_cyc, 20);
        chk("t1_id", s_rid, 0);
        chk("t1_data", s_rdata, 16'hEFFF);
        chk("t1_err", s_rerr, 0);

        upd_n = upd_cyc_q.size();
        bus.req_angle[1*W +: W] = 16'h5A5A;
        bus.req_valid[1] = 1'b1;
        bad = 0;
        repeat (10) begin
            tick();
            if (!s_rvalid || s_rdata != 16'hEFFF || s_rid != 2'd0 || s_ready != 4'b0 || s_update)
                bad++;
        end
        chk("t3_hold_stable", bad, 0);
        chk("t3_no_update", upd_cyc_q.size(), upd_n);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        chk("t3_next_grant", s_ready, 4'b0010);
        wait_rsp("t3b", 40);
        chk("t3b_id", s_rid, 1);
        chk("t3b_data", s_rdata, 16'hA5A5);
        bus.rsp_ready = 1'b1;
        tick();

        // All four at once from rr_ptr=0; req0 re-requests after its grant.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_logs();
        bus.req_angle = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        bus.req_valid = 4'b1111;
        reraised = 0;
        n = 0;
        while (rsp_id_q.size() < 5 && n < 300) begin
            tick();
            n++;
            if (reraised == 0 && grant_q.size() == 1) begin
                bus.req_angle[0*W +: W] = 16'h7777;
                bus.req_valid[0] = 1'b1;
                reraised = 1;
            end
        end
        chk("t2_rsp_count", rsp_id_q.size(), 5);
        exp_id  = '{0, 1, 2, 3, 0};
        exp_dat = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210, 16'h8888};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_grant%0d", i), grant_q[i], exp_id[i]);
            chk($sformatf("t2_rsp_id%0d", i), rsp_id_q[i], exp_id[i]);
            chk($sformatf("t2_rsp_data%0d", i), rsp_data_q[i], exp_dat[i]);
        end
        chk("t2_update_count", upd_cyc_q.size(), 5);
        mingap = 1000;
        for (int i = 1; i < upd_cyc_q.size(); i++) begin
            gap = upd_cyc_q[i] - upd_cyc_q[i-1];
            if (gap < mingap) mingap = gap;
        end
        chk("t2_update_gap_ge20", (mingap >= 20), 1);

        // Core that never goes busy: error after 64 WAIT_BUSY cycles, then normal service.
        clear_logs();
        stub_stuck = 1'b1;
        bus.req_angle[1*W +: W] = 16'h2222;
        bus.req_valid = 4'b0010;
        tick();
        chk("t4_grant", s_ready, 4'b0010);
        a_cyc = cyc;
        wait_rsp("t4", 100);
        chk("t4_latency", cyc - a_cyc, 66);
        chk("t4_err", s_rerr, 1);
        chk("t4_data", s_rdata, 0);
        chk("t4_id", s_rid, 1);
        stub_stuck = 1'b0;
        bus.req_angle[2*W +: W] = 16'h3333;
        bus.req_valid = 4'b0100;
        tick();
        chk("t4b_grant", s_ready, 4'b0100);
        wait_rsp("t4b", 40);
        chk("t4b_err", s_rerr, 0);
        chk("t4b_data", s_rdata, 16'hCCCC);
        chk("t4b_id", s_rid, 2);

        // Reset while waiting on the core drops the transaction and rr_ptr.
        clear_logs();
        bus.req_angle[2*W +: W] = 16'h4444;
        bus.req_valid = 4'b0100;
        tick();
        chk("t5_grant", s_ready, 4'b0100);
        repeat (6) tick();
        chk("t5_busy_before", s_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t5_busy_after", s_busy, 0);
        chk("t5_rsp_valid_after", s_rvalid, 0);
        bus.req_angle = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        bus.req_valid = 4'b1111;
        tick();
        chk("t5_first_grant", s_ready, 4'b0001);
        run_until("t5", 4, 200);
        chk("t5_rsp0_id", rsp_id_q[0], 0);
        chk("t5_rsp0_data", rsp_data_q[0], 16'hFFFE);
        repeat (3) tick();
        chk("t5_no_extra_rsp", rsp_id_q.size(), 4);

        // req2, then req1 and req3 together: 3 wins, then 1.
        clear_logs();
        bus.req_angle[2*W +: W] = 16'h0F0F;
        bus.req_valid = 4'b0100;
        run_until("t6a", 1, 60);
        bus.req_angle[1*W +: W] = 16'h1111;
        bus.req_angle[3*W +: W] = 16'h3333;
        bus.req_valid = 4'b1010;
        run_until("t6b", 3, 120);
        chk("t6_grant0", grant_q[0], 2);
        chk("t6_grant1", grant_q[1], 3);
        chk("t6_grant2", grant_q[2], 1);
        chk("t6_data1", rsp_data_q[1], 16'hCCCC);
        chk("t6_data2", rsp_data_q[2], 16'hEEEE);

        chk("core_angle_stable", angle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
